fu_mem_arb_2_1: RTL
===================

FU_MEM_ARB_2_1 -- requirements
Module: fu_mem_arb_2_1

Interface
REQ-001 Parameter: size, default 32, data width of both input channels and the output channel.
REQ-002 Parameter: BURST, default 4, maximum consecutive transfers one requester may take in round-robin mode; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 config_sig  input  2  mode: 00 round-robin, 01 fixed priority in0, 10 in0 only, 11 in1 only.
REQ-006 in0  input  size  requester 0 data.
REQ-007 in0_valid  input  1  requester 0 data valid.
REQ-008 in0_ready  output  1  arbiter accepts in0 this cycle.
REQ-009 in1  input  size  requester 1 data.
REQ-010 in1_valid  input  1  requester 1 data valid.
REQ-011 in1_ready  output  1  arbiter accepts in1 this cycle.
REQ-012 out0  output  size  registered selected data.
REQ-013 out0_valid  output  1  out0 holds an undelivered beat.
REQ-014 out0_ready  input  1  downstream accepts out0 this cycle.
REQ-015 out0_sel  output  1  source of the beat in out0 (0 = in0, 1 = in1), usable as select for a 2:1 memory cell.

Function
REQ-016 Transfer on channel N occurs when inN_valid and inN_ready are both 1 at a rising edge; output transfer occurs when out0_valid and out0_ready are both 1.
REQ-017 Output slot can accept when out0_valid = 0, or out0_valid = 1 and out0_ready = 1 in the same cycle.
REQ-018 At most one of in0_ready/in1_ready is 1 in any cycle; inN_ready = slot can accept AND channel N granted.
REQ-019 inN_ready is independent of inN_valid (no combinational valid-to-ready path on the same channel).
REQ-020 Grant, mode 00: only one valid -> that channel; both valid -> channel other than last_grant, unless burst_cnt < BURST and last_grant still valid, then last_grant keeps grant; neither valid -> grant the channel other than last_grant.
REQ-021 Grant, mode 01: in0 whenever in0_valid = 1, else in1.
REQ-022 Grant, modes 10/11: only in0 / only in1; the other channel's ready held at 0.
REQ-023 On input transfer: out0 <= data, out0_sel <= channel, out0_valid <= 1, last_grant <= channel; latency exactly 1 cycle from input transfer to out0_valid.
REQ-024 burst_cnt (4-bit): on transfer from same channel as last_grant -> saturating increment at BURST; from different channel -> 1; unchanged without transfer.
REQ-025 Output transfer without input transfer: out0_valid <= 0; out0 and out0_sel hold value.
REQ-026 Simultaneous output and input transfer: out0 replaced by new beat, out0_valid stays 1; no bubble, no loss.
REQ-027 out0_valid = 1 and out0_ready = 0: out0, out0_sel, out0_valid held stable until accepted.
REQ-028 config_sig change takes effect on grant in the same cycle; buffered beat in out0 unaffected; burst_cnt not cleared.
REQ-029 Data with inN_valid = 1 and inN_ready = 0 is never consumed or dropped; requester must hold it.
REQ-030 Throughput: one beat per cycle sustained when out0_ready = 1 continuously.

Reset
REQ-031 While reset = 0 at a rising edge: out0 <= 0, out0_valid <= 0, out0_sel <= 0, last_grant <= 1, burst_cnt <= 0.
REQ-032 in0_ready and in1_ready are 0 in any cycle where reset = 0.
REQ-033 Reset asserted mid-operation discards any buffered beat; first grant after release in mode 00 goes to in0 on tie.

Verification
REQ-034 Mode 00, BURST=4, both valid continuously, out0_ready=1 -> out0_sel sequence 0,0,0,0,1,1,1,1,0... starting the cycle after reset release.
REQ-035 Mode 00, in0_valid=1 only, data 0x11,0x22,0x33 -> out0 = 0x11,0x22,0x33 on consecutive cycles, out0_sel=0, in1_ready=0 throughout.
REQ-036 out0_ready=0 for 3 cycles with out0=0xA5 valid -> out0 held 0xA5, in0_ready=in1_ready=0; out0_ready=1 with in1_valid=1 data 0x5A -> next cycle out0=0x5A, out0_sel=1, out0_valid=1.
REQ-037 Mode 11, both valid -> only in1 transfers, in0_ready=0 every cycle; switch to 10 -> in0 granted same cycle.
REQ-038 Mode 01, both valid, in0 drops valid after 2 beats -> out0_sel = 0,0,1,...; in0 reasserts -> in0 granted same cycle.
REQ-039 reset=0 asserted while out0_valid=1 -> next cycle out0_valid=0, out0=0, out0_sel=0, both readies 0 while reset=0.

Source files
------------

// File: rtl/fu_mem_arb_2_1.sv
// Two-requester arbiter feeding one registered output slot; round-robin with burst, fixed-priority or forced single-channel modes.
// Latency 1 cycle input-to-out0; a ready is offered only while the slot is empty or draining, so a stalled out0 stalls both inputs.
module fu_mem_arb_2_1 #(
  parameter int size  = 32,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      config_sig,
  input  logic [size-1:0] in0,
  input  logic            in0_valid,
  output logic            in0_ready,
  input  logic [size-1:0] in1,
  input  logic            in1_valid,
  output logic            in1_ready,
  output logic [size-1:0] out0,
  output logic            out0_valid,
  input  logic            out0_ready,
  output logic            out0_sel
);

  localparam logic [3:0] BURST_L = 4'(BURST);

  logic       last_grant;
  logic [3:0] burst_cnt;
  logic       slot_ok;
  logic       gnt;
  logic       xfer0;
  logic       xfer1;
  logic       keep_last;

  assign slot_ok = !out0_valid || out0_ready;

  // A zero burst count means no streak is in progress, so a tie goes to the other channel.
  assign keep_last = (burst_cnt != 4'd0) && (burst_cnt < BURST_L);

  always_comb begin
    gnt = 1'b0;
    case (config_sig)
      2'b00: begin
        case ({in0_valid, in1_valid})
          2'b10:   gnt = 1'b0;
          2'b01:   gnt = 1'b1;
          2'b11:   gnt = keep_last ? last_grant : !last_grant;
          default: gnt = !last_grant;
        endcase
      end
      2'b01:   gnt = !in0_valid;
      2'b10:   gnt = 1'b0;
      default: gnt = 1'b1;
    endcase
  end

  assign in0_ready = reset && slot_ok && !gnt;
  assign in1_ready = reset && slot_ok && gnt;
  assign xfer0     = in0_valid && in0_ready;
  assign xfer1     = in1_valid && in1_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out0       <= '0;
      out0_valid <= 1'b0;
      out0_sel   <= 1'b0;
      last_grant <= 1'b1;
      burst_cnt  <= 4'd0;
    end else if (xfer0 || xfer1) begin
      out0       <= xfer1 ? in1 : in0;
      out0_sel   <= xfer1;
      out0_valid <= 1'b1;
      last_grant <= xfer1;
      if (xfer1 == last_grant)
        burst_cnt <= (burst_cnt >= BURST_L) ? BURST_L : burst_cnt + 4'd1;
      else
        burst_cnt <= 4'd1;
    end else if (out0_valid && out0_ready) begin
      out0_valid <= 1'b0;
    end
  end

endmodule
